// File: rtl/uart_rx_param.sv
// uart_rx_param: oversampling UART receiver with runtime baud, 5..DATA_W data bits, parity, 1/2 stop bits.
module uart_rx_param #(
  parameter int DATA_W     = 8,
  parameter int OVERSAMPLE = 16,
  parameter int DIV_W      = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [DIV_W-1:0]  baud_div,
  input  logic [3:0]        data_bits,
  input  logic              parity_en,
  input  logic              parity_odd,
  input  logic              two_stop,
  input  logic              rx,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic              rx_ready,
  output logic              frame_err,
  output logic              parity_err,
  output logic              overrun_err,
  output logic              busy
);
  localparam int TW = $clog2(OVERSAMPLE);
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP1, STOP2} state_t;
  state_t r_state, w_next;
  logic r_rx_s1, r_rx_s2, r_rx_d;
  logic [DIV_W-1:0] r_div;
  logic [TW-1:0] r_tcnt;
  logic [3:0] r_bitcnt, r_nbits, w_nbits;
  logic [DATA_W-1:0] r_shift;
  logic r_s0, r_s1, r_parbit, r_ferr, r_par_en, r_par_odd, r_two_stop;
  logic w_tick, w_start, w_maj, w_mid, w_end, w_done;
  assign w_tick  = (r_state != IDLE) && (r_div == '0);
  assign w_start = (r_state == IDLE) && r_rx_d && !r_rx_s2;
  assign w_maj   = (r_s0 & r_s1) | (r_s0 & r_rx_s2) | (r_s1 & r_rx_s2);
  assign w_mid   = w_tick && (r_tcnt == TW'(OVERSAMPLE/2+1));
  assign w_end   = w_tick && (r_tcnt == TW'(OVERSAMPLE-1));
  assign w_done  = w_mid && ((r_state == STOP1 && !r_two_stop) || r_state == STOP2);
  assign w_nbits = (data_bits >= 4'd5 && data_bits <= 4'(DATA_W)) ? data_bits : 4'(DATA_W);
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) r_state <= IDLE;
    else r_state <= w_next;
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = w_start ? START : IDLE;
      START:   w_next = (w_mid && w_maj) ? IDLE : w_end ? DATA : START;
      DATA:    w_next = (w_end && r_bitcnt == r_nbits - 4'd1) ? (r_par_en ? PARITY : STOP1) : DATA;
      PARITY:  w_next = w_end ? STOP1 : PARITY;
      STOP1:   w_next = w_done ? IDLE : w_end ? STOP2 : STOP1;
      STOP2:   w_next = w_done ? IDLE : STOP2;
      default: w_next = IDLE;
    endcase
  end
  always_comb busy = (r_state != IDLE);
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      r_rx_s1 <= 1'b1;
      r_rx_s2 <= 1'b1;
      r_rx_d <= 1'b1;
      r_div <= '0;
      r_tcnt <= '0;
      r_bitcnt <= '0;
      r_nbits <= 4'(DATA_W);
      r_shift <= '0;
      r_s0 <= 1'b1;
      r_s1 <= 1'b1;
      r_parbit <= 1'b0;
      r_ferr <= 1'b0;
      r_par_en <= 1'b0;
      r_par_odd <= 1'b0;
      r_two_stop <= 1'b0;
      rx_data <= '0;
      rx_valid <= 1'b0;
      frame_err <= 1'b0;
      parity_err <= 1'b0;
      overrun_err <= 1'b0;
    end else begin
      r_rx_s1 <= rx;
      r_rx_s2 <= r_rx_s1;
      r_rx_d <= r_rx_s2;
      if (w_start) begin
        r_div <= baud_div;
        r_tcnt <= '0;
        r_bitcnt <= '0;
        r_shift <= '0;
        r_ferr <= 1'b0;
        r_nbits <= w_nbits;
        r_par_en <= parity_en;
        r_par_odd <= parity_odd;
        r_two_stop <= two_stop;
      end else if (r_state != IDLE) begin
        r_div <= (r_div == '0) ? baud_div : r_div - DIV_W'(1);
        if (w_tick) begin
          r_tcnt <= w_end ? '0 : r_tcnt + TW'(1);
          if (r_tcnt == TW'(OVERSAMPLE/2-1)) r_s0 <= r_rx_s2;
          if (r_tcnt == TW'(OVERSAMPLE/2)) r_s1 <= r_rx_s2;
        end
        if (w_mid && r_state == DATA) r_shift <= r_shift | (DATA_W'(w_maj) << r_bitcnt);
        if (w_end && r_state == DATA) r_bitcnt <= r_bitcnt + 4'd1;
        if (w_mid && r_state == PARITY) r_parbit <= w_maj;
        if (w_mid && (r_state == STOP1 || r_state == STOP2) && !w_maj) r_ferr <= 1'b1;
      end
      // a completing word is dropped only when the pending one is not being taken this cycle
      overrun_err <= w_done && rx_valid && !rx_ready;
      if (w_done && (!rx_valid || rx_ready)) begin
        rx_data <= r_shift;
        rx_valid <= 1'b1;
        frame_err <= r_ferr | ~w_maj;
        parity_err <= r_par_en & ((^r_shift ^ r_parbit) != r_par_odd);
      end else if (rx_valid && rx_ready) rx_valid <= 1'b0;
    end
endmodule

// File: tb/tb_uart_rx_param.sv
// tb_uart_rx_param: directed frames at 64 clk/bit against hand-computed words and status.
module tb_uart_rx_param;
  localparam int BIT = 64;
  logic clk = 1'b0, reset_n = 1'b0, rx = 1'b1, rx_ready = 1'b0;
  logic parity_en = 1'b0, parity_odd = 1'b0, two_stop = 1'b0;
  logic [15:0] baud_div = 16'd3;
  logic [3:0] data_bits = 4'd8;
  logic [7:0] rx_data;
  logic rx_valid, frame_err, parity_err, overrun_err, busy;
  int checks = 0, failures = 0, ov_cnt = 0, vrise = 0, snap;
  logic prev_v = 1'b0;
  uart_rx_param dut (
    .clk(clk), .reset_n(reset_n), .baud_div(baud_div), .data_bits(data_bits),
    .parity_en(parity_en), .parity_odd(parity_odd), .two_stop(two_stop), .rx(rx),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready), .frame_err(frame_err),
    .parity_err(parity_err), .overrun_err(overrun_err), .busy(busy)
  );
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (overrun_err) ov_cnt++;
    if (rx_valid && !prev_v) vrise++;
    prev_v = rx_valid;
  end
  initial begin
    #5_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic drive_bit(input logic b);
    rx = b;
    repeat (BIT) @(negedge clk);
  endtask
  task automatic send_frame(input logic [8:0] d, input int nb, input bit pe, input bit pb, input int ns, input bit sv);
    rx = 1'b1;
    repeat (16) @(negedge clk);
    drive_bit(1'b0);
    for (int i = 0; i < nb; i++) drive_bit(d[i]);
    if (pe) drive_bit(pb);
    drive_bit(sv);
    if (ns == 2) drive_bit(1'b1);
    rx = 1'b1;
  endtask
  task automatic accept();
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
  endtask
  initial begin
    repeat (4) @(negedge clk);
    chk("rst_valid", rx_valid, 0);
    chk("rst_data", rx_data, 0);
    chk("rst_ferr", frame_err, 0);
    chk("rst_perr", parity_err, 0);
    chk("rst_ovr", overrun_err, 0);
    chk("rst_busy", busy, 0);
    reset_n = 1'b1;
    repeat (4) @(negedge clk);
    send_frame(9'h0A5, 8, 0, 0, 1, 1);
    chk("a5_valid", rx_valid, 1);
    chk("a5_data", rx_data, 8'hA5);
    chk("a5_ferr", frame_err, 0);
    chk("a5_perr", parity_err, 0);
    chk("a5_busy", busy, 0);
    repeat (100) @(negedge clk);
    chk("a5_hold_valid", rx_valid, 1);
    chk("a5_hold_data", rx_data, 8'hA5);
    accept();
    chk("a5_accepted", rx_valid, 0);
    parity_en = 1'b1;
    send_frame(9'h03C, 8, 1, 1, 1, 1);
    chk("3c_bad_data", rx_data, 8'h3C);
    chk("3c_bad_perr", parity_err, 1);
    accept();
    send_frame(9'h03C, 8, 1, 0, 1, 1);
    chk("3c_good_valid", rx_valid, 1);
    chk("3c_good_perr", parity_err, 0);
    accept();
    data_bits = 4'd7; parity_odd = 1'b1; two_stop = 1'b1;
    send_frame(9'h041, 7, 1, 1, 2, 1);
    chk("41_7o2_data", rx_data, 8'h41);
    chk("41_7o2_perr", parity_err, 0);
    chk("41_7o2_ferr", frame_err, 0);
    accept();
    data_bits = 4'd8; parity_en = 1'b0; parity_odd = 1'b0; two_stop = 1'b0;
    repeat (BIT) @(negedge clk);
    snap = vrise;
    rx = 1'b0;
    repeat (10) @(negedge clk);
    chk("fs_busy_up", busy, 1);
    repeat (10) @(negedge clk);
    rx = 1'b1;
    repeat (44) @(negedge clk);
    chk("fs_busy_down", busy, 0);
    repeat (BIT) @(negedge clk);
    chk("fs_no_valid", vrise - snap, 0);
    send_frame(9'h055, 8, 0, 0, 1, 0);
    chk("55_valid", rx_valid, 1);
    chk("55_data", rx_data, 8'h55);
    chk("55_ferr", frame_err, 1);
    accept();
    send_frame(9'h00F, 8, 0, 0, 1, 1);
    chk("0f_data", rx_data, 8'h0F);
    chk("0f_ferr", frame_err, 0);
    accept();
    snap = ov_cnt;
    send_frame(9'h011, 8, 0, 0, 1, 1);
    send_frame(9'h022, 8, 0, 0, 1, 1);
    chk("ovr_data", rx_data, 8'h11);
    chk("ovr_valid", rx_valid, 1);
    chk("ovr_pulses", ov_cnt - snap, 1);
    accept();
    chk("ovr_accepted", rx_valid, 0);
    send_frame(9'h033, 8, 0, 0, 1, 1);
    chk("33_pending", rx_valid, 1);
    rx = 1'b1;
    repeat (16) @(negedge clk);
    drive_bit(1'b0);
    drive_bit(1'b0);
    drive_bit(1'b1);
    repeat (BIT/2) @(negedge clk);
    chk("mid_busy", busy, 1);
    reset_n = 1'b0;
    rx = 1'b1;
    repeat (2) @(negedge clk);
    chk("mrst_valid", rx_valid, 0);
    chk("mrst_data", rx_data, 0);
    chk("mrst_busy", busy, 0);
    snap = vrise;
    reset_n = 1'b1;
    repeat (3 * BIT) @(negedge clk);
    chk("mrst_no_word", vrise - snap, 0);
    send_frame(9'h09E, 8, 0, 0, 1, 1);
    chk("9e_valid", rx_valid, 1);
    chk("9e_data", rx_data, 8'h9E);
    chk("9e_ferr", frame_err, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/uart_rx_param.md
# uart_rx_param

Parametrised UART receiver: the next-generation serial input stage of the UART block. It oversamples a single asynchronous RX line and supports runtime baud divisor, 5–9 data bits, optional even/odd parity and 1 or 2 stop bits. Received words go out on a valid/ready interface, with per-word frame and parity status and an overrun pulse. It sits between the pad-side RX pin and the UART register/FIFO layer.

## Interface
Parameters:
- DATA_W, 8, maximum data bits per frame (5..9); the output width.
- OVERSAMPLE, 16, ticks per bit (even, ≥4).
- DIV_W, 16, width of baud_div.

Ports:
- clk  in  1  system clock; single clock domain.
- reset_n  in  1  asynchronous, active-low reset.
- baud_div  in  DIV_W  clocks per oversample tick minus 1.
- data_bits  in  4  bits per frame, 5..DATA_W; other values are treated as DATA_W.
- parity_en  in  1  1 = parity bit present.
- parity_odd  in  1  1 = odd parity, 0 = even parity.
- two_stop  in  1  1 = two stop bits.
- rx  in  1  asynchronous serial input; idle high.
- rx_data  out  DATA_W  received word, LSB-aligned, upper bits 0.
- rx_valid  out  1  rx_data and status are valid.
- rx_ready  in  1  consumer accepts the word.
- frame_err  out  1  a stop bit sampled 0; qualified by rx_valid.
- parity_err  out  1  parity mismatch; qualified by rx_valid.
- overrun_err  out  1  one-cycle pulse: a word was lost.
- busy  out  1  a frame is in progress (state ≠ IDLE).

## Operation
- **Input synchroniser.** rx passes through a 2-FF synchroniser. Both flops reset to 1.
- **Tick generator.** A down-counter loads baud_div and emits a tick when it reaches 0. baud_div = 0 gives a tick every clk. The counter runs freely while the FSM is not in IDLE and is reloaded on start detection.
- **Configuration latch.** data_bits, parity_en, parity_odd and two_stop are latched at start detection. Changing them mid-frame has no effect on the current frame.
- **FSM states:** IDLE → START → DATA → PARITY (only if parity_en) → STOP1 → STOP2 (only if two_stop) → IDLE.
- **IDLE.** A synchronised 1→0 on rx moves to START and clears the tick-in-bit counter.
- **Sampling.** Each bit is taken as a 3-sample majority at ticks OVERSAMPLE/2-1, OVERSAMPLE/2 and OVERSAMPLE/2+1 within the bit.
- **START.** If the majority is 1, the start is false: return to IDLE with no output. Otherwise continue; a bit ends after OVERSAMPLE ticks.
- **DATA.** Bits are taken LSB first and shifted into bit index 0..data_bits-1.
- **Parity.** parity_err = (XOR of data bits ^ parity bit) ≠ parity_odd.
- **STOP.** Any stop sample of 0 sets frame_err. The second stop bit is checked only if two_stop = 1.
- **Word completion.** After the mid-bit decision of the last stop bit, the FSM returns to IDLE immediately without waiting for the bit to end. The word is written to the output register.
- **Output register.** A single entry.
  - rx_valid stays high until a cycle with rx_valid & rx_ready.
  - If a new word completes while rx_valid = 1 and rx_ready = 0, the old word and its status are kept, the new word is dropped, and overrun_err pulses for 1 cycle.
  - Completion in the same cycle as acceptance (rx_valid & rx_ready) loads the new word with no overrun.
- **Reset values.** All outputs are 0 except busy = 0; the FSM is in IDLE.
- **Reset mid-frame.** The frame is aborted and no partial word is output.

## Timing
- Bit period = (baud_div+1)·OVERSAMPLE clk.
- Start detection lags the rx pin by 2–3 clk (synchroniser).
- rx_valid rises 1 clk after the middle tick+1 of the final stop bit. frame_err and parity_err update in the same cycle as rx_valid.
- overrun_err is asserted in the cycle the dropped word would have loaded.
- busy rises 1 clk after start detection and falls in the rx_valid load cycle.
- A new start edge is accepted from the cycle after return to IDLE, which tolerates about half a bit of baud mismatch.
- Glitches shorter than 2 of the 3 sample ticks are rejected by the majority vote.

## Test plan
- **Basic 8N1.** baud_div=3, OVERSAMPLE=16 (64 clk/bit), 8N1, send 0xA5 → rx_data=0xA5, rx_valid=1, frame_err=0, parity_err=0; the word holds until rx_ready.
- **Parity.** 8E1, send 0x3C with parity bit 1 → parity_err=1 with rx_data=0x3C. Send it with parity bit 0 → parity_err=0. Repeat with 7O2, send 0x41 → correct data, no error.
- **False start.** rx low for 20 clk, then high → no rx_valid; busy returns to 0 within 1 bit period.
- **Frame error.** Send 0x55 with stop bit forced 0 → rx_valid=1, rx_data=0x55, frame_err=1. The next frame 0x0F is received correctly.
- **Overrun.** Send 0x11 then 0x22 back-to-back with rx_ready=0 → rx_data stays 0x11 and overrun_err pulses exactly once. Assert rx_ready → 0x11 is accepted and rx_valid drops.
- **Reset mid-frame.** Pulse reset_n low mid-DATA → all outputs 0, rx_valid never asserts for that frame, and a following frame 0x9E is received correctly.
